mem_access_stage: RTL and testbench

MEM stage of the 16-bit microRISC pipeline, sitting between EX and WB.
- Owns the data memory. Stores on mem_write and returns load data combinationally on mem_read.
- Forwards the EX-stage ALU result unchanged to WB.
- The memory address is taken from alu_result.

---
 rtl/mem_pkg.sv | 7 +
 rtl/data_mem.sv | 24 ++
 rtl/mem_access_stage.sv | 48 ++++
 tb/tb_mem_access_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, default depth and zero word for the microRISC MEM stage
package mem_pkg;
    localparam int DATA_W = 16;
    localparam int DEPTH = 256;
    localparam int ADDR_W = 8;
    localparam logic [DATA_W-1:0] ZERO_WORD = 16'h0000;
endpackage

// File: rtl/data_mem.sv
// data_mem: DEPTH x DATA_W register array, async clear, sync write, comb read
// Ports: clk, rst (async, active-high clear), we, addr, wdata -> rdata
module data_mem
    import mem_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int DP = DEPTH,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DP];

    always_ff @(posedge clk or posedge rst)
        if (rst) mem <= '{default: '0};
        else if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 16-bit microRISC pipeline (data memory + ALU pass-through)
// Ports: clk, rst (async, active-high), mem_read, mem_write, alu_result (word address),
//        write_data -> read_data (gated load data), mem_alu_result (pass-through)
// Optional: `define MEM_STAGE_BOUNDS_CHECK_EN adds mem_fault and blocks accesses
//           whose upper address bits are non-zero; otherwise upper bits alias.
module mem_access_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    output logic              mem_fault,
`endif
    output logic [DATA_W-1:0] mem_alu_result
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic              we;
    logic              rd_ok;

    assign addr = alu_result[ADDR_W-1:0];
    assign mem_alu_result = alu_result;

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    assign mem_fault = ~rst & (mem_read | mem_write) & (|alu_result[DATA_W-1:ADDR_W]);
    assign we = mem_write & ~mem_fault;
    assign rd_ok = mem_read & ~mem_fault;
`else
    assign we = mem_write;
    assign rd_ok = mem_read;
`endif

    assign read_data = rd_ok ? rdata : ZERO_WORD;

    data_mem u_data_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (write_data),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed + random checks of mem_access_stage against an array model
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] alu_result = 16'h0000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data;
    logic [15:0] mem_alu_result;
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    logic        mem_fault;
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    int compared = 0;
    int mismatched = 0;
    logic [15:0] model [256];

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .alu_result     (alu_result),
        .write_data     (write_data),
        .read_data      (read_data),
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        .mem_fault      (mem_fault),
`endif
        .mem_alu_result (mem_alu_result)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fault();
        return BOUNDS && !rst && (mem_read || mem_write) && alu_result[15:8] != 8'h00;
    endfunction

    function automatic logic [15:0] model_read();
        if (!mem_read || rst || model_fault()) return 16'h0000;
        return model[alu_result[7:0]];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rd"}, read_data, model_read());
        chk({tag, "_pass"}, mem_alu_result, alu_result);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        chk({tag, "_fault"}, {15'h0, mem_fault}, {15'h0, model_fault()});
`endif
    endtask

    task automatic tick();
        if (!rst && mem_write && !model_fault()) model[alu_result[7:0]] = write_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_model();
        mem_read = 1'b1;
        alu_result = 16'h0004;
        repeat (10) tick();
        chk("reset_rd", read_data, 16'h0000);
        rst = 1'b0;
        #1;
        chk("post_reset_rd", read_data, 16'h0000);
        mem_read = 1'b0;
        mem_write = 1'b1;
        write_data = 16'hABCD;
        #1;
        chk("wr_pass", mem_alu_result, 16'h0004);
        tick();
        mem_write = 1'b0;
        mem_read = 1'b1;
        #1;
        chk("rd_abcd", read_data, 16'hABCD);
        chk("rd_pass", mem_alu_result, 16'h0004);
        mem_read = 1'b0;
        #1;
        chk("gate_off", read_data, 16'h0000);
        alu_result = 16'h1234;
        #1;
        chk("pass_1234", mem_alu_result, 16'h1234);
        alu_result = 16'hFFFF;
        #1;
        chk("pass_ffff", mem_alu_result, 16'hFFFF);
        alu_result = 16'h0010;
        write_data = 16'h1111;
        mem_write = 1'b1;
        tick();
        mem_read = 1'b1;
        write_data = 16'h2222;
        #1;
        chk("rw_before", read_data, 16'h1111);
        tick();
        mem_write = 1'b0;
        #1;
        chk("rw_after", read_data, 16'h2222);
        alu_result = 16'h0020;
        write_data = 16'h5A5A;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        #1;
        chk("rd_5a5a", read_data, 16'h5A5A);
        rst = 1'b1;
        clear_model();
        #2;
        chk("async_rst_rd", read_data, 16'h0000);
        rst = 1'b0;
        #1;
        chk("after_rst_rd", read_data, 16'h0000);
        alu_result = 16'h0004;
        #1;
        chk("after_rst_w4", read_data, 16'h0000);
        mem_read = 1'b0;
        mem_write = 1'b1;
        alu_result = 16'h0104;
        write_data = 16'h7777;
        #1;
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        chk("oor_fault", {15'h0, mem_fault}, 16'h0001);
`endif
        chk("oor_pass", mem_alu_result, 16'h0104);
        tick();
        mem_write = 1'b0;
        mem_read = 1'b1;
        alu_result = 16'h0004;
        #1;
        chk("oor_w4", read_data, BOUNDS ? 16'h0000 : 16'h7777);
        for (int n = 0; n < 300; n++) begin
            mem_read = 1'($urandom);
            mem_write = 1'($urandom);
            alu_result = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom_range(0, 31))};
            write_data = 16'($urandom);
            #1;
            check_all("rand");
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
